// File: rtl/mac_row_sequencer_if.sv
// Bus bundle between the row sequencer, its image/weight memories, the
// multiply-add datapath and the classifier that consumes the decision.
interface mac_row_sequencer_if #(
   parameter int PixelRowWidth  = 24,
   parameter int WeightRowWidth = 15,
   parameter int AddrWidth      = 8,
   parameter int AccWidth       = 32,
   parameter int ResultWidth    = 27
);
   logic                      start;
   logic [AccWidth-1:0]       threshold;
   logic                      mem_rd_en;
   logic [AddrWidth-1:0]      mem_addr;
   logic [PixelRowWidth-1:0]  mem_pixel_row;
   logic [WeightRowWidth-1:0] mem_weight_row;
   logic [PixelRowWidth-1:0]  mac_pixel_row;
   logic [WeightRowWidth-1:0] mac_weight_row;
   logic [ResultWidth-1:0]    mac_result;
   logic                      busy;
   logic                      done;
   logic [AccWidth-1:0]       score;
   logic                      is_cat;
   logic                      saturated;

   modport master (
      input  start, threshold, mem_pixel_row, mem_weight_row, mac_result,
      output mem_rd_en, mem_addr, mac_pixel_row, mac_weight_row,
             busy, done, score, is_cat, saturated
   );

   modport slave (
      output start, threshold, mem_pixel_row, mem_weight_row, mac_result,
      input  mem_rd_en, mem_addr, mac_pixel_row, mac_weight_row,
             busy, done, score, is_cat, saturated
   );
endinterface

// File: rtl/mac_row_sequencer.sv
// Streams one image's pixel/weight rows into the 3-lane multiply-add datapath,
// accumulates a saturating score and compares it with a sampled threshold.
module mac_row_sequencer #(
   parameter int PixelWidth     = 8,
   parameter int WeightWidth    = 5,
   parameter int PixelRowWidth  = 24,
   parameter int WeightRowWidth = 15,
   parameter int NumRows        = 4,
   parameter int AddrWidth      = 8,
   parameter int AccWidth       = 32
) (
   input logic               clk,
   input logic               rst,
   mac_row_sequencer_if.master bus
);
   localparam int ResultWidth = 2 * (WeightWidth + PixelWidth) + 1;
   localparam int SumWidth    = ((AccWidth > ResultWidth) ? AccWidth : ResultWidth) + 1;
   localparam logic [AddrWidth-1:0] LastAddr = AddrWidth'(NumRows - 1);
   localparam logic [AccWidth-1:0]  AccMax   = {AccWidth{1'b1}};

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } seqState_t;

   seqState_t                 state_r;
   seqState_t                 stateNext_s;
   logic                      acceptStart_s;
   logic                      issueNext_s;
   logic                      finishImage_s;

   logic                      memRdEn_r;
   logic [AddrWidth-1:0]      memAddr_r;
   logic                      v1_r;
   logic                      v2_r;
   logic [PixelRowWidth-1:0]  macPixel_r;
   logic [WeightRowWidth-1:0] macWeight_r;

   logic [AccWidth-1:0]       acc_r;
   logic [AccWidth-1:0]       threshold_r;
   logic [AccWidth-1:0]       score_r;
   logic                      isCat_r;
   logic                      saturated_r;
   logic                      done_r;
   logic                      busy_r;

   logic [SumWidth-1:0]       sum_s;
   logic                      overflow_s;
   logic [AccWidth-1:0]       accNext_s;
   logic [AccWidth-1:0]       accFinal_s;

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= stateNext_s;
      end
   end

   // Next state and single-cycle control strobes. memAddr_r doubles as the row counter.
   always_comb begin
      stateNext_s   = state_r;
      acceptStart_s = 1'b0;
      issueNext_s   = 1'b0;
      finishImage_s = 1'b0;
      case (state_r)
         IDLE: begin
            if (bus.start) begin
               acceptStart_s = 1'b1;
               stateNext_s   = READ;
            end else begin
               stateNext_s   = IDLE;
            end
         end
         READ: begin
            if (memAddr_r == LastAddr) begin
               stateNext_s = DRAIN;
            end else begin
               issueNext_s = 1'b1;
               stateNext_s = READ;
            end
         end
         DRAIN: begin
            // With no row left in stage 1, this edge commits the final accumulate.
            if (!v1_r) begin
               finishImage_s = 1'b1;
               stateNext_s   = DONE;
            end else begin
               stateNext_s   = DRAIN;
            end
         end
         DONE: begin
            stateNext_s = IDLE;
         end
         default: begin
            stateNext_s = IDLE;
         end
      endcase
   end

   // Saturating unsigned add of the datapath result into the accumulator.
   always_comb begin
      sum_s      = SumWidth'(acc_r) + SumWidth'(bus.mac_result);
      overflow_s = (sum_s > SumWidth'(AccMax));
      if (overflow_s) begin
         accNext_s = AccMax;
      end else begin
         accNext_s = sum_s[AccWidth-1:0];
      end
      if (v2_r) begin
         accFinal_s = accNext_s;
      end else begin
         accFinal_s = acc_r;
      end
   end

   // Memory read issue and the two-stage operand pipeline.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         memRdEn_r   <= 1'b0;
         memAddr_r   <= {AddrWidth{1'b0}};
         v1_r        <= 1'b0;
         v2_r        <= 1'b0;
         macPixel_r  <= {PixelRowWidth{1'b0}};
         macWeight_r <= {WeightRowWidth{1'b0}};
      end else begin
         memRdEn_r <= acceptStart_s | issueNext_s;
         if (acceptStart_s) begin
            memAddr_r <= {AddrWidth{1'b0}};
         end else if (issueNext_s) begin
            memAddr_r <= memAddr_r + AddrWidth'(1);
         end else begin
            memAddr_r <= memAddr_r;
         end
         v1_r <= memRdEn_r;
         v2_r <= v1_r;
         if (v1_r) begin
            macPixel_r  <= bus.mem_pixel_row;
            macWeight_r <= bus.mem_weight_row;
         end else begin
            macPixel_r  <= macPixel_r;
            macWeight_r <= macWeight_r;
         end
      end
   end

   // Accumulator, sticky saturation flag and the held decision outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_r       <= {AccWidth{1'b0}};
         threshold_r <= {AccWidth{1'b0}};
         score_r     <= {AccWidth{1'b0}};
         isCat_r     <= 1'b0;
         saturated_r <= 1'b0;
         done_r      <= 1'b0;
         busy_r      <= 1'b0;
      end else begin
         done_r <= finishImage_s;
         busy_r <= (stateNext_s != IDLE);
         if (acceptStart_s) begin
            acc_r       <= {AccWidth{1'b0}};
            threshold_r <= bus.threshold;
            score_r     <= {AccWidth{1'b0}};
            isCat_r     <= 1'b0;
            saturated_r <= 1'b0;
         end else begin
            if (v2_r) begin
               acc_r <= accNext_s;
            end else begin
               acc_r <= acc_r;
            end
            if (v2_r && overflow_s) begin
               saturated_r <= 1'b1;
            end else begin
               saturated_r <= saturated_r;
            end
            if (finishImage_s) begin
               score_r <= accFinal_s;
               isCat_r <= (accFinal_s >= threshold_r);
            end else begin
               score_r <= score_r;
               isCat_r <= isCat_r;
            end
         end
      end
   end

   assign bus.mem_rd_en      = memRdEn_r;
   assign bus.mem_addr       = memAddr_r;
   assign bus.mac_pixel_row  = macPixel_r;
   assign bus.mac_weight_row = macWeight_r;
   assign bus.busy           = busy_r;
   assign bus.done           = done_r;
   assign bus.score          = score_r;
   assign bus.is_cat         = isCat_r;
   assign bus.saturated      = saturated_r;
endmodule

// File: tb/tb_mac_row_sequencer.sv
// Randomised bench for mac_row_sequencer: three instances (4 rows/32-bit, 4 rows/16-bit,
// 1 row/32-bit) share one memory image; results are checked against an arithmetic model.
module tb_mac_row_sequencer;
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   mac_row_sequencer_if                   busA ();
   mac_row_sequencer_if #(.AccWidth(16))  busB ();
   mac_row_sequencer_if                   busC ();

   mac_row_sequencer                  dutA (.clk(clk), .rst(rst), .bus(busA));
   mac_row_sequencer #(.AccWidth(16)) dutB (.clk(clk), .rst(rst), .bus(busB));
   mac_row_sequencer #(.NumRows(1))   dutC (.clk(clk), .rst(rst), .bus(busC));

   logic [23:0] pixMem [4];
   logic [14:0] wgtMem [4];
   int          sel = 0;
   logic        startReq = 1'b0;
   logic [31:0] thrReq = 32'd0;
   int          nCompared = 0;
   int          nMismatched = 0;
   int          rdAddrs [$];
   int          doneCount = 0;

   function automatic logic [26:0] dot3(input logic [23:0] p, input logic [14:0] w);
      int s;
      s = 0;
      for (int i = 0; i < 3; i++) s += int'(p[8*i +: 8]) * int'(w[5*i +: 5]);
      return 27'(s);
   endfunction

   assign busA.start = startReq && (sel == 0);
   assign busB.start = startReq && (sel == 1);
   assign busC.start = startReq && (sel == 2);
   assign busA.threshold = thrReq;
   assign busB.threshold = thrReq[15:0];
   assign busC.threshold = thrReq;
   assign busA.mac_result = dot3(busA.mac_pixel_row, busA.mac_weight_row);
   assign busB.mac_result = dot3(busB.mac_pixel_row, busB.mac_weight_row);
   assign busC.mac_result = dot3(busC.mac_pixel_row, busC.mac_weight_row);

   always @(posedge clk) begin
      if (busA.mem_rd_en) begin
         busA.mem_pixel_row  <= pixMem[busA.mem_addr[1:0]];
         busA.mem_weight_row <= wgtMem[busA.mem_addr[1:0]];
      end
      if (busB.mem_rd_en) begin
         busB.mem_pixel_row  <= pixMem[busB.mem_addr[1:0]];
         busB.mem_weight_row <= wgtMem[busB.mem_addr[1:0]];
      end
      if (busC.mem_rd_en) begin
         busC.mem_pixel_row  <= pixMem[busC.mem_addr[1:0]];
         busC.mem_weight_row <= wgtMem[busC.mem_addr[1:0]];
      end
   end

   logic        obsRdEn, obsDone, obsBusy, obsIsCat, obsSat;
   logic [7:0]  obsAddr;
   logic [63:0] obsScore;
   always_comb begin
      case (sel)
         0: begin
            obsRdEn = busA.mem_rd_en; obsAddr = busA.mem_addr; obsDone = busA.done;
            obsBusy = busA.busy; obsIsCat = busA.is_cat; obsSat = busA.saturated;
            obsScore = 64'(busA.score);
         end
         1: begin
            obsRdEn = busB.mem_rd_en; obsAddr = busB.mem_addr; obsDone = busB.done;
            obsBusy = busB.busy; obsIsCat = busB.is_cat; obsSat = busB.saturated;
            obsScore = 64'(busB.score);
         end
         default: begin
            obsRdEn = busC.mem_rd_en; obsAddr = busC.mem_addr; obsDone = busC.done;
            obsBusy = busC.busy; obsIsCat = busC.is_cat; obsSat = busC.saturated;
            obsScore = 64'(busC.score);
         end
      endcase
   end

   // Mid-cycle monitor of read addresses and done pulses of the selected instance.
   always @(negedge clk) begin
      if (obsRdEn) rdAddrs.push_back(int'(obsAddr));
      if (obsDone) doneCount <= doneCount + 1;
   end

   task automatic checkVal(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      nCompared++;
      if (observed !== expected) begin
         nMismatched++;
         $display("FAIL %s: observed %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
      end
   endtask

   function automatic int rowsOf(input int s);
      return (s == 2) ? 1 : 4;
   endfunction

   function automatic longint maxOf(input int s);
      return (s == 1) ? 64'd65535 : 64'd4294967295;
   endfunction

   // Score of one image: sum of all lane products over the rows, clipped to the accumulator range.
   function automatic longint refScore(input int s);
      longint total;
      total = 0;
      for (int r = 0; r < rowsOf(s); r++) total += longint'(dot3(pixMem[r], wgtMem[r]));
      return (total > maxOf(s)) ? maxOf(s) : total;
   endfunction

   function automatic bit refSat(input int s);
      longint total;
      total = 0;
      for (int r = 0; r < rowsOf(s); r++) total += longint'(dot3(pixMem[r], wgtMem[r]));
      return total > maxOf(s);
   endfunction

   task automatic fillRows(input int mode);
      for (int r = 0; r < 4; r++) begin
         case (mode)
            0: begin pixMem[r] = {8'd1, 8'd1, 8'd1};       wgtMem[r] = {5'd1, 5'd1, 5'd1}; end
            1: begin pixMem[r] = {8'd255, 8'd255, 8'd255}; wgtMem[r] = {5'd31, 5'd31, 5'd31}; end
            2: begin pixMem[r] = 24'd0;                    wgtMem[r] = 15'd0; end
            default: begin pixMem[r] = 24'($urandom); wgtMem[r] = 15'($urandom); end
         endcase
      end
   endtask

   task automatic runImage(input int s, input logic [31:0] thr, input bit noisy);
      int     rows, doneAt, rdBase, doneBase;
      longint expScore, thrEff;
      rows     = rowsOf(s);
      expScore = refScore(s);
      thrEff   = (s == 1) ? longint'(thr[15:0]) : longint'(thr);
      sel      = s;
      rdBase   = rdAddrs.size();
      doneBase = doneCount;
      @(negedge clk);
      thrReq   = thr;
      startReq = 1'b1;
      @(posedge clk);
      #1;
      startReq = 1'b0;
      if (noisy) thrReq = ~thr;
      checkVal("busyAfterStart", 64'(obsBusy), 64'd1);
      doneAt = 0;
      for (int c = 1; c <= 40 && doneAt == 0; c++) begin
         if (noisy) startReq = (c == 2);
         @(posedge clk);
         #1;
         if (obsDone) doneAt = c;
      end
      checkVal("doneLatency", 64'(doneAt), 64'(rows + 2));
      if (noisy) startReq = 1'b1;
      @(posedge clk);
      #1;
      startReq = 1'b0;
      checkVal("donePulseWidth", 64'(obsDone), 64'd0);
      checkVal("idleAfterDone", 64'(obsBusy), 64'd0);
      checkVal("readCount", 64'(rdAddrs.size() - rdBase), 64'(rows));
      for (int i = 0; i < rows && rdBase + i < rdAddrs.size(); i++)
         checkVal("readAddr", 64'(rdAddrs[rdBase + i]), 64'(i));
      checkVal("doneCount", 64'(doneCount - doneBase), 64'd1);
      checkVal("score", obsScore, 64'(expScore));
      checkVal("isCat", 64'(obsIsCat), 64'(expScore >= thrEff));
      checkVal("saturated", 64'(obsSat), 64'(refSat(s)));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout, expected completion");
      $fatal(1, "simulation time limit");
   end

   initial begin
      fillRows(0);
      #2 rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checkVal("rstRdEn", 64'(busA.mem_rd_en), 64'd0);
      checkVal("rstAddr", 64'(busA.mem_addr), 64'd0);
      checkVal("rstBusy", 64'(busA.busy), 64'd0);
      checkVal("rstDone", 64'(busA.done), 64'd0);
      checkVal("rstScore", 64'(busA.score), 64'd0);
      checkVal("rstOperand", 64'(busA.mac_pixel_row), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Unit data, threshold at and just above the score.
      runImage(0, 32'd12, 1'b0);
      runImage(0, 32'd13, 1'b0);
      fillRows(1);
      runImage(0, 32'd94860, 1'b0);

      // Saturation on the narrow accumulator, then cleared by a fresh image.
      runImage(1, 32'd0, 1'b0);
      fillRows(2);
      runImage(1, 32'd5, 1'b0);

      // Ignored starts while busy and in DONE, then a back-to-back start.
      fillRows(0);
      runImage(0, 32'd12, 1'b1);
      runImage(0, 32'd12, 1'b0);

      // Asynchronous reset mid-READ after address 1 is issued.
      sel = 0;
      @(negedge clk);
      thrReq = 32'd12;
      startReq = 1'b1;
      @(posedge clk);
      #1;
      startReq = 1'b0;
      @(posedge clk);
      #1;
      checkVal("addrBeforeReset", 64'(busA.mem_addr), 64'd1);
      #2;
      rst = 1'b1;
      #1;
      checkVal("abortRdEn", 64'(busA.mem_rd_en), 64'd0);
      checkVal("abortAddr", 64'(busA.mem_addr), 64'd0);
      checkVal("abortBusy", 64'(busA.busy), 64'd0);
      checkVal("abortOperand", 64'(busA.mac_pixel_row), 64'd0);
      begin
         int doneBase;
         doneBase = doneCount;
         repeat (2) @(negedge clk);
         rst = 1'b0;
         repeat (8) @(posedge clk);
         #1;
         checkVal("abortNoDone", 64'(doneCount - doneBase), 64'd0);
         checkVal("abortIdle", 64'(busA.busy), 64'd0);
      end
      runImage(0, 32'd12, 1'b0);

      // Single-row instance.
      pixMem[0] = {8'd30, 8'd20, 8'd10};
      wgtMem[0] = {5'd3, 5'd2, 5'd1};
      runImage(2, 32'd0, 1'b0);
      runImage(2, 32'd141, 1'b0);

      // Random images with thresholds straddling the expected score.
      for (int r = 0; r < 12; r++) begin
         int     s;
         longint e;
         s = r % 3;
         fillRows(3);
         e = refScore(s);
         case (r % 4)
            0: runImage(s, 32'(e), (r % 5) == 0);
            1: runImage(s, 32'(e + 1), 1'b0);
            2: runImage(s, 32'(e - 1), 1'b0);
            default: runImage(s, $urandom, 1'b0);
         endcase
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end
endmodule
